config_screen_ctrl: RTL

Configuration-mode controller for the clock screen. It turns debounced push-button pulses into the `config_mode` and `cursor_location` codes consumed by the character generator, and holds the three 2-digit BCD fields being edited. It also generates the cursor blink and issues a one-cycle write strobe toward the RTC interface when a configuration mode is left. It sits between the button debouncers, the RTC register bank and the screen top.

---
 rtl/config_screen_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/config_screen_ctrl.sv
// Purpose : configuration-mode controller for the clock screen (mode FSM, cursor, BCD edit fields, blink, commit strobe).
// Latency : one cycle; a button pulse sampled at edge N is visible on the registered outputs during cycle N+1.
// Backpr. : none; inputs are one-cycle pulses, one action per cycle (config > right > left > up > down), others dropped.
// Ports   : clock/reset (sync, active-high); btn_* pulses; live_{time,date,tmr}_f0..f2 packed BCD sources;
//           config_mode, cursor_location, edit_f0..f2, cursor_blink, write_strobe/write_sel toward RTC.
module config_screen_ctrl #(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_config,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] live_time_f0,
  input  logic [7:0] live_time_f1,
  input  logic [7:0] live_time_f2,
  input  logic [7:0] live_date_f0,
  input  logic [7:0] live_date_f1,
  input  logic [7:0] live_date_f2,
  input  logic [7:0] live_tmr_f0,
  input  logic [7:0] live_tmr_f1,
  input  logic [7:0] live_tmr_f2,
  output logic [1:0] config_mode,
  output logic [1:0] cursor_location,
  output logic [7:0] edit_f0,
  output logic [7:0] edit_f1,
  output logic [7:0] edit_f2,
  output logic       cursor_blink,
  output logic       write_strobe,
  output logic [1:0] write_sel
);

  localparam int            CW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_TIME  = 2'd1,
    MODE_DATE  = 2'd2,
    MODE_TIMER = 2'd3
  } mode_e;

  mode_e         mode_q, mode_d, mode_nxt;
  logic [1:0]    cursor_q, cursor_d;
  logic [7:0]    f0_q, f0_d, f1_q, f1_d, f2_q, f2_d;
  logic          blink_q, blink_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;
  logic [1:0]    sel_q, sel_d;

  // Field under the cursor and its legal range for the current mode.
  logic [7:0] cur_val, cur_max_bcd, up_val, down_val, cur_new;
  logic [6:0] cur_bin, cur_min, cur_max;
  logic       cur_ok, is_date;

  always_comb begin
    case (cursor_q)
      2'd1:    cur_val = f1_q;
      2'd2:    cur_val = f2_q;
      default: cur_val = f0_q;
    endcase
    is_date = (mode_q == MODE_DATE);
    cur_ok  = (cur_val[7:4] <= 4'd9) && (cur_val[3:0] <= 4'd9);
    // Only meaningful when cur_ok; out-of-range nibbles are caught by cur_ok first.
    cur_bin = 7'(cur_val[7:4]) * 7'd10 + 7'(cur_val[3:0]);
    // DATE day and month start at 1; every other field starts at 0.
    cur_min = (is_date && cursor_q != 2'd2) ? 7'd1 : 7'd0;
    case (cursor_q)
      2'd1: begin
        cur_max     = is_date ? 7'd12  : 7'd59;
        cur_max_bcd = is_date ? 8'h12  : 8'h59;
      end
      2'd2: begin
        cur_max     = is_date ? 7'd99  : 7'd59;
        cur_max_bcd = is_date ? 8'h99  : 8'h59;
      end
      default: begin
        cur_max     = is_date ? 7'd31  : 7'd23;
        cur_max_bcd = is_date ? 8'h31  : 8'h23;
      end
    endcase

    // Increment wraps to min; invalid BCD also snaps to min.
    if (!cur_ok || cur_bin >= cur_max)
      up_val = {4'h0, cur_min[3:0]};
    else if (cur_val[3:0] == 4'd9)
      up_val = {cur_val[7:4] + 4'd1, 4'd0};
    else
      up_val = {cur_val[7:4], cur_val[3:0] + 4'd1};

    // Decrement wraps to max; invalid BCD or above-range values snap to max.
    if (!cur_ok || cur_bin <= cur_min || cur_bin > cur_max)
      down_val = cur_max_bcd;
    else if (cur_val[3:0] == 4'd0)
      down_val = {cur_val[7:4] - 4'd1, 4'd9};
    else
      down_val = {cur_val[7:4], cur_val[3:0] - 4'd1};
  end

  always_comb begin
    case (mode_q)
      MODE_RUN:  mode_nxt = MODE_TIME;
      MODE_TIME: mode_nxt = MODE_DATE;
      MODE_DATE: mode_nxt = MODE_TIMER;
      default:   mode_nxt = MODE_RUN;
    endcase
  end

  always_comb begin
    mode_d   = mode_q;
    cursor_d = cursor_q;
    f0_d     = f0_q;
    f1_d     = f1_q;
    f2_d     = f2_q;
    blink_d  = blink_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    sel_d    = 2'd0;
    cur_new  = btn_up ? up_val : down_val;

    if (btn_config) begin
      mode_d = mode_nxt;
      cnt_d  = '0;
      // Leaving an edit mode commits it; DATE->TIMER commits DATE while loading TIMER in the same cycle.
      if (mode_q != MODE_RUN) begin
        strobe_d = 1'b1;
        sel_d    = mode_q;
      end
      if (mode_nxt == MODE_RUN) begin
        blink_d = 1'b0;
      end else begin
        blink_d  = 1'b1;
        cursor_d = 2'd0;
        case (mode_nxt)
          MODE_TIME: begin f0_d = live_time_f0; f1_d = live_time_f1; f2_d = live_time_f2; end
          MODE_DATE: begin f0_d = live_date_f0; f1_d = live_date_f1; f2_d = live_date_f2; end
          default:   begin f0_d = live_tmr_f0;  f1_d = live_tmr_f1;  f2_d = live_tmr_f2;  end
        endcase
      end
    end else if (mode_q == MODE_RUN) begin
      blink_d = 1'b0;
      cnt_d   = '0;
    end else if (btn_right || btn_left || btn_up || btn_down) begin
      cnt_d   = '0;
      blink_d = 1'b1;
      if (btn_right) begin
        cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
      end else if (btn_left) begin
        cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
      end else begin
        case (cursor_q)
          2'd1:    f1_d = cur_new;
          2'd2:    f2_d = cur_new;
          default: f0_d = cur_new;
        endcase
      end
    end else if (cnt_q == BLINK_LAST) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q   <= MODE_RUN;
      cursor_q <= 2'd0;
      f0_q     <= 8'h00;
      f1_q     <= 8'h00;
      f2_q     <= 8'h00;
      blink_q  <= 1'b0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      sel_q    <= 2'd0;
    end else begin
      mode_q   <= mode_d;
      cursor_q <= cursor_d;
      f0_q     <= f0_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
      blink_q  <= blink_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      sel_q    <= sel_d;
    end
  end

  assign config_mode     = mode_q;
  assign cursor_location = cursor_q;
  assign edit_f0         = f0_q;
  assign edit_f1         = f1_q;
  assign edit_f2         = f2_q;
  assign cursor_blink    = blink_q;
  assign write_strobe    = strobe_q;
  assign write_sel       = sel_q;

endmodule
